alu_issue: RTL and testbench
============================

# alu_issue

Operand-issue and result-capture sequencer between instruction fetch and the combinational `ALU` in KGP-RISC. It accepts one instruction word per transaction and reads its source registers from the register file. It drives `inp1`/`inp2`/`opcode`/`fcode` into the ALU, registers the result, `ext_out` and the four flags, then presents a writeback beat under a valid/ready handshake. It is the producer side of the ALU port and the consumer of its outputs.

## Interface
- `DATA_W`, 32: datapath width; matches ALU operand width.
- `RADDR_W`, 5: register-file address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction word offered.
- `instr_ready` out 1: block can accept; high only in IDLE.
- `instr` in 32: [31:29] opcode, [28:25] fcode, [24:20] rd, [19:15] rs, [14:10] rt, [14:0] imm15.
- `rf_raddr_a` / `rf_raddr_b` out `RADDR_W`: register-file read addresses; rs and rt.
- `rf_rdata_a` / `rf_rdata_b` in `DATA_W`: read data, one cycle after the address.
- `alu_inp1`, `alu_inp2` out `DATA_W`: ALU operands.
- `alu_opcode` out 3, `alu_fcode` out 4: ALU selects.
- `alu_out`, `alu_ext_out` in `DATA_W`: ALU results.
- `alu_carry`, `alu_zero`, `alu_sign`, `alu_ovf` in 1: ALU flags.
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake.
- `wb_addr` out `RADDR_W`, `wb_data` out `DATA_W`, `wb_ext` out `DATA_W`: writeback payload.
- `flags_q` out 4: {carry, zero, sign, ovf} from the last executed instruction.
- `err_illegal` out 1: one-cycle pulse on an illegal opcode.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` into `ir_q`.
  - Opcode 0 (reg-reg) or 1 (reg-imm): go to READ.
  - Any other opcode: pulse `err_illegal` on the next cycle and stay in IDLE. No register read, no flag update, no writeback.
- READ: drive `rf_raddr_a`=rs and `rf_raddr_b`=rt. Go to EXEC.
- EXEC: drive the ALU combinationally from the registered read data.
  - `alu_inp1`=`rf_rdata_a`.
  - `alu_inp2`=`rf_rdata_b` for opcode 0. For opcode 1 it is imm15 sign-extended to `DATA_W` (bit 14 replicated).
  - `alu_opcode`/`alu_fcode` come from `ir_q`.
  - At the clock edge, capture `alu_out`→`wb_data`, `alu_ext_out`→`wb_ext`, rd→`wb_addr`, and the four flags→`flags_q`.
  - rd≠0: go to WB. rd=0: go to IDLE with the result discarded; flags are still updated.
- WB: `wb_valid`=1 and the payload is held stable. Leave for IDLE on the cycle `wb_valid && wb_ready`.
- Outside EXEC, the ALU drive outputs are 0 and the read addresses hold their last value.

## Timing
- Reset values: `instr_ready`=0 during reset and 1 at the first edge after release (state IDLE). All other outputs are 0.
- Reset is asynchronous and overrides any state, including mid-WB. A pending writeback is dropped and `wb_valid` falls immediately.
- Latency: instruction accepted at edge N → READ cycle N+1 → EXEC cycle N+2 → `wb_valid` high from cycle N+3. Minimum 4 cycles per instruction.
- Throughput: at most one instruction in flight. `instr_ready`=0 from the accepting edge until return to IDLE.
- `wb_ready` low holds WB indefinitely with `wb_data`/`wb_ext`/`wb_addr`/`flags_q` unchanged.
- `wb_ready` may be high before `wb_valid`; completion takes exactly one WB cycle.
- `flags_q` changes only at the EXEC edge.

## Structure
- Shared package `kgp_pkg`: opcode constants `OP_RR`=3'd0 and `OP_RI`=3'd1, instruction field bit positions, FSM state encoding, `DATA_W`/`RADDR_W` defaults.
- One natural sub-module: `imm_sext`, a parameterised sign extender from imm15 to `DATA_W`, reused later by the branch unit.
- The ALU is instantiated by the parent and is not inside this block.

## Test plan
- Reg-reg add: r2=2, r3=3, instr {op 0, fcode 0, rd 4, rs 2, rt 3} → `wb_valid` at N+3, `wb_addr`=4, `wb_data`=5, `flags_q`=0000.
- Reg-imm: r2=2, {op 1, fcode 0, rd 5, rs 2, imm15=0x7FFD} → `alu_inp2`=0xFFFFFFFD in EXEC and `wb_data`=0xFFFFFFFF. `flags_q` sign bit=1.
- rd=0: {op 0, rd 0} with r1=0, r2=0 → no `wb_valid`. `flags_q` zero bit=1 and `instr_ready` returns at N+3.
- Backpressure: hold `wb_ready`=0 for 5 cycles after `wb_valid` → payload stable and `instr_ready`=0. Releasing `wb_ready` gives IDLE on the next cycle.
- Illegal opcode 3'd5 → `err_illegal` is a one-cycle pulse, no ALU drive, no `wb_valid`, `flags_q` unchanged.
- Reset asserted in WB → `wb_valid`=0 asynchronously, `flags_q`=0. After release, the next instruction executes normally.

Source files
------------

// File: rtl/kgp_pkg.sv
// kgp_pkg: shared definitions for the KGP-RISC issue path.
// Contents:
//   - default datapath/register-address widths
//   - opcode constants OP_RR / OP_RI
//   - instruction field bit positions
//   - issue FSM state encoding
//   - is_legal_op(): opcodes the ALU issue path accepts
package kgp_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    localparam logic [2:0] OP_RR = 3'd0;
    localparam logic [2:0] OP_RI = 3'd1;

    // Instruction field positions: [31:29] op, [28:25] fcode, [24:20] rd,
    // [19:15] rs, [14:10] rt, [14:0] imm15
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 29;
    localparam int unsigned FC_MSB  = 28;
    localparam int unsigned FC_LSB  = 25;
    localparam int unsigned RD_MSB  = 24;
    localparam int unsigned RD_LSB  = 20;
    localparam int unsigned RS_MSB  = 19;
    localparam int unsigned RS_LSB  = 15;
    localparam int unsigned RT_MSB  = 14;
    localparam int unsigned RT_LSB  = 10;
    localparam int unsigned IMM_W   = 15;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } issue_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_RR) || (op == OP_RI);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles every non-clock signal of alu_issue.
//   instruction handshake : instr_valid, instr_ready, instr
//   register-file read    : rf_raddr_a/b (to RF), rf_rdata_a/b (from RF, 1-cycle latency)
//   ALU drive             : alu_inp1/2, alu_opcode, alu_fcode
//   ALU results           : alu_out, alu_ext_out, alu_carry/zero/sign/ovf
//   writeback             : wb_valid, wb_ready, wb_addr, wb_data, wb_ext
//   status                : flags_q, err_illegal, busy
// Modports: master = the issue block, slave = its environment.
interface alu_issue_if
    import kgp_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
);
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [RADDR_W-1:0] rf_raddr_a;
    logic [RADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0]  rf_rdata_a;
    logic [DATA_W-1:0]  rf_rdata_b;
    logic [DATA_W-1:0]  alu_inp1;
    logic [DATA_W-1:0]  alu_inp2;
    logic [2:0]         alu_opcode;
    logic [3:0]         alu_fcode;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  alu_ext_out;
    logic               alu_carry;
    logic               alu_zero;
    logic               alu_sign;
    logic               alu_ovf;
    logic               wb_valid;
    logic               wb_ready;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic [DATA_W-1:0]  wb_ext;
    logic [3:0]         flags_q;
    logic               err_illegal;
    logic               busy;

    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b,
        input  alu_out, alu_ext_out, alu_carry, alu_zero, alu_sign, alu_ovf, wb_ready,
        output instr_ready, rf_raddr_a, rf_raddr_b, alu_inp1, alu_inp2, alu_opcode,
        output alu_fcode, wb_valid, wb_addr, wb_data, wb_ext, flags_q, err_illegal, busy
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b,
        output alu_out, alu_ext_out, alu_carry, alu_zero, alu_sign, alu_ovf, wb_ready,
        input  instr_ready, rf_raddr_a, rf_raddr_b, alu_inp1, alu_inp2, alu_opcode,
        input  alu_fcode, wb_valid, wb_addr, wb_data, wb_ext, flags_q, err_illegal, busy
    );

endinterface

// File: rtl/imm_sext.sv
// imm_sext: sign-extends an IN_W-bit immediate to OUT_W bits.
//   imm : immediate in
//   ext : sign-extended immediate out
module imm_sext #(
    parameter int unsigned IN_W  = 15,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext
);

    assign ext = {{(OUT_W - IN_W){imm[IN_W-1]}}, imm};

endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand-issue and result-capture sequencer for the KGP-RISC ALU.
// Accepts one instruction at a time (IDLE), reads rs/rt from the register file
// (READ), drives the external combinational ALU and captures its results (EXEC),
// then offers a writeback beat under valid/ready (WB).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : alu_issue_if.master, all handshake / RF / ALU / writeback signals
module alu_issue
    import kgp_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input logic         clk,
    input logic         rst,
    alu_issue_if.master bus
);

    issue_state_e       state_q;
    logic [31:0]        ir_q;
    logic               instr_ready_q;
    logic               busy_q;
    logic               err_q;
    logic [RADDR_W-1:0] raddr_a_q;
    logic [RADDR_W-1:0] raddr_b_q;
    logic               wb_valid_q;
    logic [RADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [DATA_W-1:0]  wb_ext_q;
    logic [3:0]         flags_q;
    logic [DATA_W-1:0]  imm_ext;

    // rs is consumed straight from the incoming word at accept time
    logic unused_ir_rs;
    assign unused_ir_rs = ^ir_q[RS_MSB:RS_LSB];

    imm_sext #(
        .IN_W  (IMM_W),
        .OUT_W (DATA_W)
    ) u_imm_sext (
        .imm (ir_q[IMM_W-1:0]),
        .ext (imm_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            ir_q          <= '0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            raddr_a_q     <= '0;
            raddr_b_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            wb_ext_q      <= '0;
            flags_q       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Also raises instr_ready on the first edge after reset
                    instr_ready_q <= 1'b1;
                    if (bus.instr_valid && instr_ready_q) begin
                        ir_q <= bus.instr;
                        if (is_legal_op(bus.instr[OPC_MSB:OPC_LSB])) begin
                            raddr_a_q     <= bus.instr[RS_MSB:RS_LSB];
                            raddr_b_q     <= bus.instr[RT_MSB:RT_LSB];
                            instr_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                            state_q       <= StRead;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state_q <= StExec;
                end
                StExec: begin
                    flags_q <= {bus.alu_carry, bus.alu_zero, bus.alu_sign, bus.alu_ovf};
                    if (ir_q[RD_MSB:RD_LSB] != '0) begin
                        wb_addr_q  <= ir_q[RD_MSB:RD_LSB];
                        wb_data_q  <= bus.alu_out;
                        wb_ext_q   <= bus.alu_ext_out;
                        wb_valid_q <= 1'b1;
                        state_q    <= StWb;
                    end else begin
                        // r0 is hardwired: drop the result, keep the flags
                        instr_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                StWb: begin
                    if (bus.wb_ready) begin
                        wb_valid_q    <= 1'b0;
                        instr_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ALU operands are only driven during EXEC so the ALU sees zeros otherwise
    always_comb begin
        bus.alu_inp1   = '0;
        bus.alu_inp2   = '0;
        bus.alu_opcode = '0;
        bus.alu_fcode  = '0;
        if (state_q == StExec) begin
            bus.alu_inp1   = bus.rf_rdata_a;
            bus.alu_inp2   = (ir_q[OPC_MSB:OPC_LSB] == OP_RI) ? imm_ext : bus.rf_rdata_b;
            bus.alu_opcode = ir_q[OPC_MSB:OPC_LSB];
            bus.alu_fcode  = ir_q[FC_MSB:FC_LSB];
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.err_illegal = err_q;
    assign bus.rf_raddr_a  = raddr_a_q;
    assign bus.rf_raddr_b  = raddr_b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_ext      = wb_ext_q;
    assign bus.flags_q     = flags_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed + short random bench for alu_issue.
// Provides a registered-read register file and a small combinational ALU
// (fcode 0 add, 1 and, else or; ext_out = a ^ b). Expected writeback beats go
// into a scoreboard queue at issue time and are popped when wb_valid appears.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ext;
        logic [3:0]  flags;
    } alu_res_t;

    typedef struct packed {
        logic [4:0] addr;
        alu_res_t   res;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sb_q[$];
    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(32), .RADDR_W(5)) bus ();

    alu_issue #(
        .DATA_W  (32),
        .RADDR_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic alu_res_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] fc);
        alu_res_t   r;
        logic [32:0] s;
        logic       c;
        logic       o;
        s = '0;
        c = 1'b0;
        o = 1'b0;
        case (fc)
            4'd0: begin
                s      = {1'b0, a} + {1'b0, b};
                r.data = s[31:0];
                c      = s[32];
                o      = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'd1:    r.data = a & b;
            default: r.data = a | b;
        endcase
        r.ext   = a ^ b;
        r.flags = {c, (r.data == 32'd0), r.data[31], o};
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] fc,
                                       input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [14:0] low);
        return {op, fc, rd, rs, low};
    endfunction

    // Register file with one-cycle read latency
    always @(posedge clk) begin
        bus.rf_rdata_a <= rf_mem[bus.rf_raddr_a];
        bus.rf_rdata_b <= rf_mem[bus.rf_raddr_b];
    end

    alu_res_t alu_now;
    always_comb begin
        alu_now         = ref_alu(bus.alu_inp1, bus.alu_inp2, bus.alu_fcode);
        bus.alu_out     = alu_now.data;
        bus.alu_ext_out = alu_now.ext;
        bus.alu_carry   = alu_now.flags[3];
        bus.alu_zero    = alu_now.flags[2];
        bus.alu_sign    = alu_now.flags[1];
        bus.alu_ovf     = alu_now.flags[0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        sb_t e;
        n_vec++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_addr"},  64'(bus.wb_addr),  64'(e.addr));
            check({tag, "_data"},  64'(bus.wb_data),  64'(e.res.data));
            check({tag, "_ext"},   64'(bus.wb_ext),   64'(e.res.ext));
            check({tag, "_flags"}, 64'(bus.flags_q),  64'(e.res.flags));
        end
    endtask

    // Issue one legal instruction with wb_ready high and wait (bounded) for its beat
    task automatic run_txn(input string tag, input logic [31:0] ins);
        bit got;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.wb_ready    = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.wb_valid) got = 1'b1;
            else tick();
        end
        check({tag, "_wb_seen"}, 64'(got), 64'd1);
        if (got) begin
            pop_compare(tag);
            tick();
            check({tag, "_idle"}, 64'({bus.wb_valid, bus.instr_ready}), 64'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t      e;
        logic [31:0] ins;
        logic [2:0]  op;
        logic [3:0]  fc;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [14:0] imm;
        logic [31:0] b;

        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[2] = 32'd2;
        rf_mem[3] = 32'd3;
        rf_mem[9] = 32'h8000_0000;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.wb_ready    = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_instr_ready", 64'(bus.instr_ready), 64'd0);
        check("rst_outputs", 64'({bus.wb_valid, bus.busy, bus.err_illegal, bus.flags_q}),
              64'd0);
        check("rst_wb_payload", 64'({bus.wb_addr, bus.wb_data}), 64'd0);
        rst = 1'b0;
        check("rel_instr_ready_low", 64'(bus.instr_ready), 64'd0);
        tick();
        check("rel_instr_ready_high", 64'(bus.instr_ready), 64'd1);

        // Reg-reg add, wb_ready already high: r4 = r2 + r3
        e.addr = 5'd4; e.res.data = 32'd5; e.res.ext = 32'd1; e.res.flags = 4'b0000;
        sb_q.push_back(e);
        bus.wb_ready    = 1'b1;
        bus.instr       = mk(3'd0, 4'd0, 5'd4, 5'd2, {5'd3, 10'd0});
        bus.instr_valid = 1'b1;
        tick();                                     // accept edge N
        bus.instr_valid = 1'b0;
        check("rr_read_ready_busy", 64'({bus.instr_ready, bus.busy}), 64'b01);
        check("rr_raddr", 64'({bus.rf_raddr_a, bus.rf_raddr_b}), 64'({5'd2, 5'd3}));
        check("rr_read_no_drive", 64'(bus.alu_inp1), 64'd0);
        tick();                                     // EXEC
        check("rr_exec_ops", 64'({bus.alu_inp1, bus.alu_inp2}), {32'd2, 32'd3});
        check("rr_exec_sel", 64'({bus.alu_opcode, bus.alu_fcode}), 64'd0);
        check("rr_exec_no_wb", 64'(bus.wb_valid), 64'd0);
        tick();                                     // N+3: WB
        check("rr_wb_valid", 64'(bus.wb_valid), 64'd1);
        pop_compare("rr");
        tick();
        check("rr_one_wb_cycle", 64'({bus.wb_valid, bus.instr_ready, bus.busy}), 64'b010);

        // Reg-imm: r5 = r2 + sext(0x7FFD)
        e.addr = 5'd5; e.res.data = 32'hFFFF_FFFF; e.res.ext = 32'hFFFF_FFFF;
        e.res.flags = 4'b0010;
        sb_q.push_back(e);
        bus.instr       = mk(3'd1, 4'd0, 5'd5, 5'd2, 15'h7FFD);
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        check("ri_exec_inp2", 64'(bus.alu_inp2), 64'hFFFF_FFFD);
        check("ri_exec_opcode", 64'(bus.alu_opcode), 64'd1);
        tick();
        check("ri_wb_valid", 64'(bus.wb_valid), 64'd1);
        pop_compare("ri");
        tick();

        // rd = 0: flags only, no writeback
        rf_mem[1] = 32'd0;
        bus.instr       = mk(3'd0, 4'd0, 5'd0, 5'd1, {5'd1, 10'd0});
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();                                     // N+3
        check("rd0_no_wb", 64'(bus.wb_valid), 64'd0);
        check("rd0_ready_back", 64'({bus.instr_ready, bus.busy}), 64'b10);
        check("rd0_flags", 64'(bus.flags_q), 64'b0100);

        // Backpressure: r7 = r3 + r3 held for 5 cycles
        e.addr = 5'd7; e.res.data = 32'd6; e.res.ext = 32'd0; e.res.flags = 4'b0000;
        sb_q.push_back(e);
        bus.wb_ready    = 1'b0;
        bus.instr       = mk(3'd0, 4'd0, 5'd7, 5'd3, {5'd3, 10'd0});
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        check("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
        pop_compare("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid_ready", 64'({bus.wb_valid, bus.instr_ready}), 64'b10);
            check("bp_hold_payload", 64'({bus.wb_addr, bus.wb_data, bus.flags_q}),
                  64'({5'd7, 32'd6, 4'b0000}));
        end
        bus.wb_ready = 1'b1;
        tick();
        check("bp_release", 64'({bus.wb_valid, bus.instr_ready}), 64'b01);

        // Illegal opcode 5
        bus.instr       = mk(3'd5, 4'd3, 5'd6, 5'd2, {5'd3, 10'd0});
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("ill_pulse", 64'({bus.err_illegal, bus.instr_ready, bus.busy}), 64'b110);
        check("ill_no_drive", 64'({bus.alu_inp1, bus.alu_opcode, bus.alu_fcode}), 64'd0);
        tick();
        check("ill_pulse_end", 64'({bus.err_illegal, bus.wb_valid}), 64'b00);
        tick();
        check("ill_flags_kept", 64'({bus.flags_q, bus.wb_valid, bus.busy}), 64'd0);

        // Reset while in WB: r8 = r9 + r9 = 0 with carry/zero/ovf set
        e.addr = 5'd8; e.res.data = 32'd0; e.res.ext = 32'd0; e.res.flags = 4'b1101;
        sb_q.push_back(e);
        bus.wb_ready    = 1'b0;
        bus.instr       = mk(3'd0, 4'd0, 5'd8, 5'd9, {5'd9, 10'd0});
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        check("rwb_wb_valid", 64'(bus.wb_valid), 64'd1);
        pop_compare("rwb");
        #2 rst = 1'b1;
        #1;
        check("rwb_async_drop", 64'({bus.wb_valid, bus.flags_q, bus.busy}), 64'd0);
        check("rwb_async_ready", 64'(bus.instr_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rwb_ready_after", 64'(bus.instr_ready), 64'd1);

        // Random legal instructions after the reset
        for (int k = 0; k < 8; k++) begin
            rs  = 5'($urandom_range(10, 20));
            rt  = 5'($urandom_range(10, 20));
            rf_mem[rs] = $urandom;
            rf_mem[rt] = $urandom;
            op  = 3'($urandom_range(0, 1));
            fc  = 4'($urandom_range(0, 2));
            rd  = 5'($urandom_range(1, 31));
            imm = 15'($urandom);
            if (op == 3'd0) imm = {rt, imm[9:0]};
            b   = (op == 3'd1) ? {{17{imm[14]}}, imm} : rf_mem[imm[14:10]];
            e.addr = rd;
            e.res  = ref_alu(rf_mem[rs], b, fc);
            sb_q.push_back(e);
            ins = mk(op, fc, rd, rs, imm);
            run_txn("rnd", ins);
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
